// File: rtl/uut_run_pkg.sv
// Shared types and constants for the UUT run sequencer.
package uut_run_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL_CLK,
        RST_HOLD,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] CLK_SEL_DIV4 = 2'b00;
    localparam logic [1:0] CLK_SEL_DIV2 = 2'b01;
    localparam logic [1:0] CLK_SEL_MAX  = 2'b10;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser bringing a single asynchronous bit into the clk domain.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uut_run_sequencer.sv
// Sequences one measured UUT run: clock select, settle, reset hold, then a
// cycle-counted run that ends on UUT completion, timeout or abort.
module uut_run_sequencer
    import uut_run_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int SETTLE_CYCLES = 8,
    parameter int RST_CYCLES    = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       clk_sel_req,
    input  logic [CNT_W-1:0] timeout_limit,
    input  logic             end_uut,
    output logic             rst_uut,
    output logic [1:0]       clk_uut_sel,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             aborted,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int PH_MAX = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;
    logic             armed_q, armed_d;
    logic             rst_uut_q, rst_uut_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             aborted_q, aborted_d;
    logic             end_sync;

    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_end_sync (
        .clk(clk),
        .rst(rst),
        .d  (end_uut),
        .q  (end_sync)
    );

    // Saturating increment; exit checks use the post-increment value so the
    // count reported in DONE equals the number of RUN cycles spent.
    assign count_inc = (&count_q) ? count_q : count_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        sel_d     = sel_q;
        limit_d   = limit_q;
        count_d   = count_q;
        armed_d   = armed_q;
        rst_uut_d = rst_uut_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        aborted_d = aborted_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SEL_CLK;
                    phase_d   = '0;
                    sel_d     = clk_sel_req;
                    limit_d   = timeout_limit;
                    count_d   = '0;
                    timeout_d = 1'b0;
                    aborted_d = 1'b0;
                    rst_uut_d = 1'b1;
                end
            end
            SEL_CLK: begin
                if (phase_q == PH_W'(SETTLE_CYCLES - 1)) begin
                    state_d = RST_HOLD;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            RST_HOLD: begin
                armed_d = 1'b0;
                if (phase_q == PH_W'(RST_CYCLES - 1)) begin
                    state_d   = RUN;
                    rst_uut_d = 1'b0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            RUN: begin
                count_d = count_inc;
                // A level already high at release must fall before it can count as completion.
                if (!end_sync) begin
                    armed_d = 1'b1;
                end
                if (armed_q && end_sync) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if ((limit_q != '0) && (count_inc == limit_q)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    rst_uut_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q == SEL_CLK || state_q == RST_HOLD || state_q == RUN)) begin
            state_d   = DONE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
            timeout_d = 1'b0;
            rst_uut_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            sel_q     <= CLK_SEL_MAX;
            limit_q   <= '0;
            count_q   <= '0;
            armed_q   <= 1'b0;
            rst_uut_q <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            sel_q     <= sel_d;
            limit_q   <= limit_d;
            count_q   <= count_d;
            armed_q   <= armed_d;
            rst_uut_q <= rst_uut_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            aborted_q <= aborted_d;
        end
    end

    assign rst_uut     = rst_uut_q;
    assign clk_uut_sel = sel_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign aborted     = aborted_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_uut_run_sequencer.sv
// Scoreboard bench for uut_run_sequencer: a driver plays runs and queues the
// expected outcome; a monitor compares it whenever done pulses.
module tb_uut_run_sequencer;

    localparam int CNT_W = 32;
    localparam int S     = 8;
    localparam int R     = 16;
    localparam int SYNC  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [1:0]       clk_sel_req;
    logic [CNT_W-1:0] timeout_limit;
    logic             end_uut;
    logic             rst_uut;
    logic [1:0]       clk_uut_sel;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             aborted;
    logic [CNT_W-1:0] cycle_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        longint cnt;
        bit     tmo;
        bit     ab;
        bit     rstu;
    } exp_t;

    exp_t sb[$];

    uut_run_sequencer #(
        .CNT_W(CNT_W), .SETTLE_CYCLES(S), .RST_CYCLES(R), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .clk_sel_req(clk_sel_req), .timeout_limit(timeout_limit), .end_uut(end_uut),
        .rst_uut(rst_uut), .clk_uut_sel(clk_uut_sel), .busy(busy), .done(done),
        .timeout(timeout), .aborted(aborted), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Outcome of a run from event times in RUN cycles: end_uut raised after RUN
    // edge d is seen SYNC+1 cycles later; abort during RUN cycle a; limit lim.
    // Earliest event wins, ties resolved abort > completion > timeout.
    function automatic exp_t model(input longint lim, input longint d, input longint a);
        longint inf;
        longint comp;
        longint tmo;
        longint ab;
        exp_t   e;
        inf  = 64'h7fff_ffff_ffff;
        comp = (d == 0) ? inf : d + SYNC + 1;
        tmo  = (lim == 0) ? inf : lim;
        ab   = (a == 0) ? inf : a;
        if (ab <= comp && ab <= tmo) begin
            e.cnt = ab;   e.tmo = 1'b0; e.ab = 1'b1; e.rstu = 1'b1;
        end else if (comp <= tmo) begin
            e.cnt = comp; e.tmo = 1'b0; e.ab = 1'b0; e.rstu = 1'b0;
        end else begin
            e.cnt = tmo;  e.tmo = 1'b1; e.ab = 1'b0; e.rstu = 1'b1;
        end
        return e;
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rst_uut"}, rst_uut, 1);
        chk({tag, "_clk_uut_sel"}, clk_uut_sel, 2);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_aborted"}, aborted, 0);
        chk({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    // One run. d: RUN edge after which end_uut rises (0 = never);
    // a: RUN cycle carrying abort, with a start pulse alongside (0 = never);
    // rst_at: RUN edge at which rst is pulsed instead of finishing (0 = never).
    task automatic run(input logic [1:0] sel, input longint lim, input longint d,
                       input longint a, input int rst_at);
        exp_t e;
        int   k;
        e = model(lim, d, a);
        if (rst_at == 0) sb.push_back(e);
        clk_sel_req   = sel;
        timeout_limit = CNT_W'(lim);
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("sel_at_T+1", clk_uut_sel, sel);
        chk("busy_after_start", busy, 1);
        chk("count_cleared", cycle_count, 0);
        repeat (S + R - 1) @(posedge clk);
        #1;
        chk("rst_uut_held", rst_uut, 1);
        chk("sel_stable", clk_uut_sel, sel);
        @(posedge clk); #1;
        chk("rst_uut_fall_T+25", rst_uut, 0);
        k = 0;
        while (1) begin
            if (rst_at != 0 && k == rst_at) begin
                chk("count_before_rst", cycle_count, k);
                rst = 1'b1;
                #1;
                chk_reset_values("midrun_rst");
                #2 rst = 1'b0;
                break;
            end
            if (!busy) break;
            if (k >= 1000) begin
                failures++;
                checks++;
                $display("FAIL run_budget: got busy after %0d cycles expected idle", k);
                break;
            end
            if (d != 0 && k == d) end_uut = 1'b1;
            if (a != 0 && k == a - 1) begin
                abort = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        start   = 1'b0;
        abort   = 1'b0;
        end_uut = 1'b0;
        if (rst_at == 0) begin
            chk("post_rst_uut", rst_uut, e.rstu);
            chk("post_timeout_sticky", timeout, e.tmo);
            chk("post_aborted_sticky", aborted, e.ab);
            chk("post_count_frozen", cycle_count, e.cnt);
            @(posedge clk); #1;
            chk("stays_idle", busy, 0);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending run");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle_count", cycle_count, e.cnt);
                chk("done_timeout", timeout, e.tmo);
                chk("done_aborted", aborted, e.ab);
                chk("done_rst_uut", rst_uut, e.rstu);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sel;
        longint     lim;
        longint     d;
        longint     a;
        rst = 1'b1; start = 1'b0; abort = 1'b0; end_uut = 1'b0;
        clk_sel_req = 2'b00; timeout_limit = '0;
        @(posedge clk); #1;
        chk_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run(2'b01, 0, 100, 0, 0);         // completion, count 103
        run(2'b00, 50, 0, 0, 0);          // timeout at 50
        end_uut = 1'b1;                   // stale high end through the whole run
        run(2'b11, 60, 0, 0, 0);
        run(2'b10, 0, 20, 0, 0);          // fresh edge completes normally
        run(2'b01, 0, 0, 5, 0);           // abort on 5th RUN cycle, start ignored
        run(2'b00, 40, 37, 0, 0);         // completion and timeout collide
        run(2'b01, 0, 0, 0, 30);          // reset mid-RUN
        run(2'b10, 0, 10, 0, 0);          // normal run after reset

        for (int i = 0; i < 10; i++) begin
            sel = 2'($urandom_range(0, 3));
            d   = longint'($urandom_range(1, 80));
            lim = ($urandom_range(0, 2) == 0) ? 0 : longint'($urandom_range(1, 90));
            a   = ($urandom_range(0, 2) == 0) ? longint'($urandom_range(1, 90)) : 0;
            run(sel, lim, d, a, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uut_run_sequencer.md
Name: uut_run_sequencer

Overview:
Sequences one measured run of the unit under test (UUT) on behalf of the autotest control unit. On each start it:
- selects the UUT clock source;
- holds the UUT in reset while the clock mux settles;
- releases reset and counts system-clock cycles until the UUT signals end, or until a programmable timeout.
It sits between the autotest FSM and the UUT clock generator / UUT reset. It owns rst_uut and clk_uut_sel, so the FSM only issues start and reads results.

Parameters:
- CNT_W, 32, width of the cycle counter and the timeout limit.
- SETTLE_CYCLES, 8, clk cycles held in reset after a clock-select change before the reset phase begins (min 1).
- RST_CYCLES, 16, clk cycles rst_uut is held during the reset phase (min 1).
- SYNC_STAGES, 2, flip-flop stages synchronising end_uut into the clk domain (min 2).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle run request; honoured only in IDLE.
- abort, in, 1, level; terminates any active run.
- clk_sel_req, in, 2, requested UUT clock: 00 = clk_max/4, 01 = clk_max/2, 1x = clk_max.
- timeout_limit, in, CNT_W, maximum run cycles; 0 = no timeout.
- end_uut, in, 1, UUT completion flag, asynchronous to clk.
- rst_uut, out, 1, UUT reset, active-high.
- clk_uut_sel, out, 2, select to the UUT clock generator.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse when a run finishes (end, timeout or abort).
- timeout, out, 1, sticky status: last run hit the timeout.
- aborted, out, 1, sticky status: last run was aborted.
- cycle_count, out, CNT_W, clk cycles spent in RUN during the last run.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, rst_uut=1, clk_uut_sel=2'b10, busy=0, done=0, timeout=0, aborted=0, cycle_count=0, synchroniser flops 0.
- IDLE:
  - start=1 latches clk_sel_req and timeout_limit, clears cycle_count, timeout and aborted, sets rst_uut=1, then goes to SEL_CLK.
  - start outside IDLE is ignored.
- SEL_CLK:
  - clk_uut_sel takes the latched value on the entry cycle; rst_uut=1.
  - Stays exactly SETTLE_CYCLES cycles, then goes to RST_HOLD.
  - clk_uut_sel changes only in this state.
- RST_HOLD:
  - rst_uut=1 for exactly RST_CYCLES cycles, then goes to RUN.
  - Clears the armed flag.
- RUN:
  - rst_uut=0 from the first RUN cycle.
  - cycle_count increments every RUN cycle, reading 1 after the first; it saturates at all-ones.
  - Armed flag sets when synchronised end_uut is 0.
  - Completion: armed=1 and synchronised end_uut=1. A stale high end_uut left in the synchroniser is never taken as completion.
  - Timeout: timeout_limit≠0 and cycle_count==timeout_limit.
  - Any exit goes to DONE.
- Simultaneous completion and timeout in the same cycle: completion wins, timeout=0.
- DONE:
  - One cycle; done=1.
  - On completion, rst_uut stays 0 so UUT outputs remain readable until the next start.
  - On timeout, timeout=1 and rst_uut=1.
  - Then goes to IDLE.
- Abort:
  - abort=1 in SEL_CLK, RST_HOLD or RUN goes to DONE next cycle with aborted=1 and rst_uut=1. cycle_count freezes.
  - abort in IDLE or DONE has no effect.
  - Abort has priority over completion and timeout in the same cycle.
- Latency: start accepted at cycle T gives:
  - clk_uut_sel valid at T+1;
  - rst_uut falls at T+1+SETTLE_CYCLES+RST_CYCLES;
  - done asserts one cycle after the exit condition.
- end_uut detection latency: SYNC_STAGES clk cycles, plus one for the registered check. This latency is included in cycle_count; the verification engineer budgets SYNC_STAGES+1.
- Reset mid-run: all state returns to reset values immediately (asynchronous); the UUT returns to reset.

Decomposition:
- Package uut_run_pkg:
  - state enum {IDLE, SEL_CLK, RST_HOLD, RUN, DONE};
  - clock-select constants CLK_SEL_DIV4=2'b00, CLK_SEL_DIV2=2'b01, CLK_SEL_MAX=2'b10.
- Sub-module bit_synchronizer (parameter STAGES, async active-high reset to 0) for end_uut.
- Counters are inline.

Test Plan:
- Reset, then start with clk_sel_req=01 and limit=0. UUT model raises end_uut 100 clk after rst_uut falls. Expected:
  - clk_uut_sel=01 at T+1;
  - rst_uut falls at T+25;
  - done pulse;
  - cycle_count=100+SYNC_STAGES+1=103, timeout=0, rst_uut stays 0.
- timeout_limit=50, end_uut never rises. Expected: done after 50 RUN cycles, timeout=1, cycle_count=50, rst_uut=1.
- end_uut held at 1 through the reset phase and beyond. Expected: no completion; timeout fires at the limit. end_uut then dropped and raised on the next run completes normally.
- abort asserted on the 5th RUN cycle. Expected: done next cycle, aborted=1, cycle_count=5, rst_uut=1. A start during the abort cycle is ignored.
- end_uut timed so its synchronised edge lands in the same cycle cycle_count==timeout_limit=40. Expected: timeout=0 and done once.
- rst asserted mid-RUN with cycle_count=30. Expected: outputs return to reset values the same cycle; a subsequent start runs normally from cycle_count=0.
